// File: rtl/inst_rom_responder.sv
`default_nettype none
// ============================================================================
//  Module      : inst_rom_responder
//  Description : ROM-side responder for the fetch stage's two-phase
//                trigger/ready handshake. Each triggerIn transition is one
//                word read from an internal, preloadable program memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_rom_responder #(
    parameter int          DEPTH     = 256,
    parameter int          ADDR_BITS = 8,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] OOR_DATA  = 32'hE1A00000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 triggerIn,
    input  logic [31:0]          addrIn,
    output logic [31:0]          dataOut,
    output logic                 readyOut,
    input  logic                 wrEn,
    input  logic [ADDR_BITS-1:0] wrAddr,
    input  logic [31:0]          wrData,
    output logic                 errOut
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_WAIT = 2'd1;
    localparam logic [1:0]  S_READ = 2'd2;

    localparam logic [31:0] c_depthWord = 32'(DEPTH);
    localparam logic [3:0]  c_latency   = 4'(LATENCY);

    logic [31:0]          r_mem [DEPTH];
    logic                 r_s1;
    logic                 r_s2;
    logic                 r_ph;
    logic [1:0]           r_state;
    logic [1:0]           w_nextState;
    logic                 w_pending;
    logic [3:0]           r_cnt;
    logic [31:0]          r_addrLat;
    logic                 r_readyReg;
    logic [31:0]          r_dataOut;
    logic                 r_errOut;

    // Two-flop synchronizer for the asynchronous request phase; no reset needed.
    always_ff @(posedge clk) begin
        r_s1 <= triggerIn;
        r_s2 <= r_s1;
    end

    // Preload write port; blocked while reset is held, contents survive reset.
    always_ff @(posedge clk) begin
        if (reset && wrEn) begin
            r_mem[wrAddr] <= wrData;
        end
    end

    assign w_pending = (r_s2 != r_ph);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state: detect in IDLE, optional wait cycles, one READ cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pending) begin
                    w_nextState = (c_latency != 4'd0) ? S_WAIT : S_READ;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_nextState = S_READ;
                end
            end
            S_READ: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Request capture, wait countdown and response registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // Adopt the current synchronized level so it is not seen as a request.
            r_ph       <= r_s2;
            r_readyReg <= 1'b0;
            r_dataOut  <= 32'd0;
            r_errOut   <= 1'b0;
            r_cnt      <= 4'd0;
            r_addrLat  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pending) begin
                        r_ph       <= r_s2;
                        r_addrLat  <= addrIn;
                        r_readyReg <= 1'b0;
                        r_cnt      <= c_latency;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                end
                S_READ: begin
                    // Full 32-bit compare: any nonzero upper bit is out of range.
                    if (r_addrLat >= c_depthWord) begin
                        r_dataOut <= OOR_DATA;
                        r_errOut  <= 1'b1;
                    end else begin
                        r_dataOut <= r_mem[r_addrLat[ADDR_BITS-1:0]];
                    end
                    r_readyReg <= 1'b1;
                end
                default: begin
                    r_readyReg <= 1'b0;
                end
            endcase
        end
    end

    // Raw-trigger gate drops ready the instant fetch issues a new phase.
    assign readyOut = r_readyReg & (triggerIn == r_ph);
    assign dataOut  = r_dataOut;
    assign errOut   = r_errOut;

endmodule
`default_nettype wire

// File: tb/tb_inst_rom_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_rom_responder
//  Description : Scoreboard bench for inst_rom_responder (LATENCY=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_rom_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        triggerIn;
    logic [31:0] addrIn;
    logic [31:0] dataOut;
    logic        readyOut;
    logic        wrEn;
    logic [7:0]  wrAddr;
    logic [31:0] wrData;
    logic        errOut;

    int          nChecks = 0;
    int          nFails  = 0;
    int          respCount = 0;
    logic [31:0] expQ[$];
    logic        monEn = 1'b0;
    logic [31:0] lastData;
    logic        lastReady;

    inst_rom_responder #(
        .DEPTH(256), .ADDR_BITS(8), .LATENCY(1), .OOR_DATA(32'hE1A00000)
    ) dut (
        .clk(clk), .reset(reset), .triggerIn(triggerIn), .addrIn(addrIn),
        .dataOut(dataOut), .readyOut(readyOut), .wrEn(wrEn), .wrAddr(wrAddr),
        .wrData(wrData), .errOut(errOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // A response is a rising readyOut or a fresh dataOut value.
    always @(negedge clk) begin
        if (monEn) begin
            if ((readyOut && !lastReady) || (dataOut !== lastData)) begin
                if (expQ.size() == 0) begin
                    chk("spurious", 32'(expQ.size()), 32'd1);
                end else begin
                    chk("data", dataOut, expQ.pop_front());
                end
                respCount++;
            end
            lastReady = readyOut;
            lastData  = dataOut;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitResp(input int target, input int limit, output int edges);
        edges = 0;
        while (respCount < target && edges < limit) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            #1;
        end
        if (respCount < target) chk("timeout", 32'(respCount), 32'(target));
    endtask

    task automatic doReq(input logic [31:0] addr, input logic [31:0] exp);
        int edges;
        int base;
        addrIn = addr;
        tick();
        base = respCount;
        triggerIn = ~triggerIn;
        expQ.push_back(exp);
        #1;
        chk("readyDrop", 32'(readyOut), 32'd0);
        waitResp(base + 1, 20, edges);
        chk("latencyOk", 32'(edges >= 5 && edges <= 6), 32'd1);
        chk("readyHigh", 32'(readyOut), 32'd1);
    endtask

    task automatic doReset(input int cycles);
        monEn = 1'b0;
        reset = 1'b0;
        repeat (cycles) tick();
        reset = 1'b1;
        tick();
        lastData  = dataOut;
        lastReady = readyOut;
        monEn = 1'b1;
    endtask

    initial begin
        int edges;
        int base;
        logic [31:0] initWords [4];
        initWords[0] = 32'h11111111;
        initWords[1] = 32'h22222222;
        initWords[2] = 32'h33333333;
        initWords[3] = 32'h44444444;
        reset = 1'b0; triggerIn = 1'b0; addrIn = 32'd0;
        wrEn = 1'b0; wrAddr = 8'd0; wrData = 32'd0;
        doReset(4);

        // Preload, then reset again and check reset values.
        monEn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wrEn = 1'b1; wrAddr = 8'(i); wrData = initWords[i];
            tick();
        end
        wrEn = 1'b0;
        doReset(3);
        chk("rstReady", 32'(readyOut), 32'd0);
        chk("rstData",  dataOut, 32'd0);
        chk("rstErr",   32'(errOut), 32'd0);

        // 1: single read.
        doReq(32'd2, 32'h33333333);
        chk("t1Err", 32'(errOut), 32'd0);

        // 2: sequential reads.
        for (int i = 0; i < 4; i++) doReq(32'(i), initWords[i]);

        // 3: out-of-range, sticky error.
        doReq(32'h00000100, 32'hE1A00000);
        chk("t3Err", 32'(errOut), 32'd1);
        doReq(32'd1, 32'h22222222);
        chk("t3ErrSticky", 32'(errOut), 32'd1);

        // 4: second toggle while the first read is waiting.
        doReq(32'd0, 32'h11111111);
        addrIn = 32'd1;
        tick();
        base = respCount;
        triggerIn = ~triggerIn;
        expQ.push_back(32'h22222222);
        repeat (3) @(posedge clk);
        #1;
        addrIn = 32'd3;
        @(negedge clk);
        triggerIn = ~triggerIn;
        expQ.push_back(32'h44444444);
        waitResp(base + 2, 30, edges);
        chk("t4Ready", 32'(readyOut), 32'd1);

        // 5: write colliding with READ returns old data.
        addrIn = 32'd1;
        tick();
        base = respCount;
        triggerIn = ~triggerIn;
        expQ.push_back(32'h22222222);
        repeat (4) @(posedge clk);
        #1;
        wrEn = 1'b1; wrAddr = 8'd1; wrData = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        wrEn = 1'b0;
        waitResp(base + 1, 10, edges);
        doReq(32'd1, 32'hDEADBEEF);

        // 6a: trigger raised during reset is not a request.
        monEn = 1'b0;
        reset = 1'b0;
        triggerIn = 1'b1;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        lastData = dataOut; lastReady = readyOut; monEn = 1'b1;
        base = respCount;
        repeat (12) tick();
        chk("t6aReady", 32'(readyOut), 32'd0);
        chk("t6aNoResp", 32'(respCount - base), 32'd0);
        chk("t6aErr", 32'(errOut), 32'd0);

        // 6b: reset mid-WAIT aborts the read.
        addrIn = 32'd0;
        tick();
        triggerIn = ~triggerIn;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (12) tick();
        chk("t6bReady", 32'(readyOut), 32'd0);
        chk("t6bNoResp", 32'(respCount - base), 32'd0);

        // 6c: normal service after release.
        doReq(32'd2, 32'h33333333);
        chk("t6cErr", 32'(errOut), 32'd0);

        chk("sbEmpty", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
